// File: rtl/display_pkg.sv
// Shared sizing, FSM encoding and bank-slot helper for the 3x3 BCD digit
// display loader.
package display_pkg;

    localparam int N_ELEM   = 9;
    localparam int DATA_W   = 8;
    localparam int N_DIGITS = 3;
    localparam int BCD_W    = N_DIGITS * 4;
    localparam int BANK_W   = N_ELEM * BCD_W;
    localparam int WORK_W   = BCD_W + DATA_W;
    localparam int IDX_W    = 4;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        STORE,
        WAIT_VBLANK
    } state_t;

    function automatic int slot_lsb(input int k);
        return k * BCD_W;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one add-3/shift step per clock, DATA_W steps
// per conversion; done is high during the final step.
module bin2bcd_seq
    import display_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] bin,
    output logic              busy,
    output logic              done,
    output logic [BCD_W-1:0]  bcd
);

    localparam logic [2:0] LAST_IT = 3'(DATA_W - 1);
    localparam logic [2:0] PREV_IT = 3'(DATA_W - 2);

    logic [WORK_W-1:0] work;
    logic [2:0]        cnt;

    function automatic logic [WORK_W-1:0] dd_step(input logic [WORK_W-1:0] w);
        logic [WORK_W-1:0] t;
        t = w;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (t[DATA_W+4*i +: 4] >= 4'd5)
                t[DATA_W+4*i +: 4] = t[DATA_W+4*i +: 4] + 4'd3;
        end
        return {t[WORK_W-2:0], 1'b0};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (start) begin
            work <= {{BCD_W{1'b0}}, bin};
            cnt  <= '0;
            busy <= 1'b1;
            done <= 1'b0;
        end else if (busy) begin
            work <= dd_step(work);
            cnt  <= cnt + 3'd1;
            done <= (cnt == PREV_IT);
            if (cnt == LAST_IT)
                busy <= 1'b0;
        end else begin
            done <= 1'b0;
        end
    end

    assign bcd = work[WORK_W-1:DATA_W];

endmodule

// File: rtl/matrix_digit_loader.sv
// Loads a 9-element matrix into a shadow BCD bank and commits the whole
// frame to the displayed bank only during vertical blanking.
module matrix_digit_loader
    import display_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              vblank,
    output logic [BANK_W-1:0] bcd_out,
    output logic              frame_pending,
    output logic              commit_pulse,
    output logic              frame_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               last_q;
    logic               vblank_q;
    logic [BANK_W-1:0]  shadow;
    logic [BANK_W-1:0]  active;
    logic               conv_busy;
    logic               conv_done;
    logic [BCD_W-1:0]   conv_bcd;
    logic               accept;

    assign accept  = in_valid && in_ready && (state == IDLE) && !conv_busy;
    assign bcd_out = active;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .reset (reset),
        .start (accept),
        .bin   (in_data),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            last_q        <= 1'b0;
            vblank_q      <= 1'b0;
            shadow        <= '0;
            active        <= '0;
            in_ready      <= 1'b1;
            frame_pending <= 1'b0;
            commit_pulse  <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            vblank_q     <= vblank;
            commit_pulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        last_q   <= in_last;
                        in_ready <= 1'b0;
                        state    <= CONVERT;
                    end
                end
                CONVERT: begin
                    if (conv_done)
                        state <= STORE;
                end
                STORE: begin
                    shadow[slot_lsb(int'(idx)) +: BCD_W] <= conv_bcd;
                    if (idx == LAST_IDX) begin
                        idx           <= '0;
                        frame_pending <= 1'b1;
                        state         <= WAIT_VBLANK;
                        if (!last_q)
                            frame_err <= 1'b1;
                    end else if (last_q) begin
                        // short frame: discard it, keep showing the old one
                        frame_err <= 1'b1;
                        idx       <= '0;
                        shadow    <= '0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        idx      <= idx + 1'b1;
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                WAIT_VBLANK: begin
                    if (vblank_q) begin
                        active        <= shadow;
                        commit_pulse  <= 1'b1;
                        frame_pending <= 1'b0;
                        in_ready      <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_digit_loader.sv
// Directed and random frames checked against a decimal-arithmetic model of
// the displayed digit bank.
module tb_matrix_digit_loader;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic [7:0]   in_data = 8'd0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic         vblank = 1'b0;
    logic [107:0] bcd_out;
    logic         frame_pending;
    logic         commit_pulse;
    logic         frame_err;

    matrix_digit_loader dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .vblank        (vblank),
        .bcd_out       (bcd_out),
        .frame_pending (frame_pending),
        .commit_pulse  (commit_pulse),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_commit = 0;
    int last_acc = 0;
    int fv[9];
    logic [11:0] exp_act[9];

    always @(posedge clk) cyc++;
    always @(negedge clk) if (commit_pulse === 1'b1) n_commit++;

    function automatic logic [11:0] to_bcd(input int v);
        return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    function automatic logic [107:0] exp_bank();
        logic [107:0] r;
        for (int k = 0; k < 9; k++) r[12*k +: 12] = exp_act[k];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] o,
                       input logic [127:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic send(input int v, input logic l, input bit sp);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data = 8'(v);
        in_last = l;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 128'(n < 200), 1);
        if (sp) chk("accept_gap", 128'(cyc - last_acc), 10);
        last_acc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic send_frame(input int nel, input int last_at, input bit rnd,
                              input bit sp, input bit pulse);
        for (int i = 0; i < nel; i++) begin
            if (rnd) fv[i] = int'($urandom_range(0, 255));
            send(fv[i], (i == last_at), sp && (i > 0));
            if (pulse && i < nel - 1) begin
                vblank = 1'b1;
                @(negedge clk);
                @(negedge clk);
                vblank = 1'b0;
            end
        end
    endtask

    task automatic wait_commit(input int lim, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (commit_pulse !== 1'b1 && n < lim);
        chk("commit_seen", 128'(commit_pulse), 1);
    endtask

    task automatic model_commit();
        for (int k = 0; k < 9; k++) exp_act[k] = to_bcd(fv[k]);
    endtask

    task automatic commit_tail(input string tag);
        chk({tag, "_bank"}, 128'(bcd_out), 128'(exp_bank()));
        chk({tag, "_pend_clr"}, 128'(frame_pending), 0);
        @(negedge clk);
        chk({tag, "_pulse_width"}, 128'(commit_pulse), 0);
        vblank = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 9; k++) exp_act[k] = '0;
        @(negedge clk);
    endtask

    initial begin
        int n, c0, ready_hi;
        for (int k = 0; k < 9; k++) exp_act[k] = '0;

        // reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 128'(in_ready), 1);
        chk("rst_bank", 128'(bcd_out), 0);
        chk("rst_pend", 128'(frame_pending), 0);
        chk("rst_err", 128'(frame_err), 0);
        chk("rst_commit", 128'(commit_pulse), 0);

        // directed frame, continuous valid, vblank low while loading
        fv = '{255, 9, 100, 0, 1, 10, 99, 128, 42};
        @(posedge clk);
        #1;
        send_frame(9, 8, 1'b0, 1'b1, 1'b0);
        ready_hi = 0;
        repeat (20) begin
            @(negedge clk);
            if (in_ready !== 1'b0) ready_hi++;
        end
        #1;
        chk("a_ready_held", 128'(ready_hi), 0);
        chk("a_pending", 128'(frame_pending), 1);
        chk("a_no_commit", 128'(n_commit), 0);
        chk("a_bank_old", 128'(bcd_out), 0);
        vblank = 1'b1;
        wait_commit(10, n);
        chk("a_commit_lat", 128'(n <= 3), 1);
        model_commit();
        chk("a_slot0", 128'(bcd_out[11:0]), 128'h255);
        chk("a_slot1", 128'(bcd_out[23:12]), 128'h009);
        chk("a_slot2", 128'(bcd_out[35:24]), 128'h100);
        chk("a_slot8", 128'(bcd_out[107:96]), 128'h042);
        commit_tail("a");
        chk("a_err", 128'(frame_err), 0);

        // reset in the middle of a conversion
        send(77, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 9; k++) exp_act[k] = '0;
        c0 = n_commit;
        @(negedge clk);
        #1;
        chk("mid_rst_ready", 128'(in_ready), 1);
        chk("mid_rst_bank", 128'(bcd_out), 0);
        chk("mid_rst_err", 128'(frame_err), 0);
        chk("mid_rst_pend", 128'(frame_pending), 0);
        chk("mid_rst_commit", 128'(n_commit), 128'(c0));

        // random frame, vblank pulses while loading, vblank high before STORE
        @(posedge clk);
        #1;
        c0 = n_commit;
        send_frame(9, 8, 1'b1, 1'b0, 1'b1);
        vblank = 1'b1;
        wait_commit(30, n);
        chk("b_commit_lat", 128'(n <= 12), 1);
        #1;
        chk("b_one_commit", 128'(n_commit), 128'(c0 + 1));
        model_commit();
        commit_tail("b");

        // missing last: error flagged but frame still commits
        @(posedge clk);
        #1;
        send_frame(9, -1, 1'b1, 1'b0, 1'b0);
        repeat (12) @(negedge clk);
        chk("c_err", 128'(frame_err), 1);
        chk("c_pending", 128'(frame_pending), 1);
        vblank = 1'b1;
        wait_commit(10, n);
        model_commit();
        commit_tail("c");

        // fresh start, good frame, then an early last
        do_reset();
        chk("r2_err", 128'(frame_err), 0);
        @(posedge clk);
        #1;
        send_frame(9, 8, 1'b1, 1'b1, 1'b0);
        vblank = 1'b1;
        wait_commit(30, n);
        model_commit();
        commit_tail("f");
        chk("f_err", 128'(frame_err), 0);

        @(posedge clk);
        #1;
        c0 = n_commit;
        send_frame(5, 4, 1'b1, 1'b0, 1'b0);
        repeat (12) @(negedge clk);
        chk("d_err", 128'(frame_err), 1);
        chk("d_pending", 128'(frame_pending), 0);
        chk("d_ready", 128'(in_ready), 1);
        vblank = 1'b1;
        repeat (10) @(negedge clk);
        vblank = 1'b0;
        #1;
        chk("d_no_commit", 128'(n_commit), 128'(c0));
        chk("d_bank_kept", 128'(bcd_out), 128'(exp_bank()));

        @(posedge clk);
        #1;
        send_frame(9, 8, 1'b1, 1'b1, 1'b0);
        vblank = 1'b1;
        wait_commit(30, n);
        model_commit();
        commit_tail("e");
        chk("e_err_sticky", 128'(frame_err), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
